simon_decrypt: RTL

SIMON_DECRYPT -- requirements
Module: simon_decrypt

---
 rtl/simon_pkg.sv | 38 +++
 rtl/simon_decrypt_if.sv | 17 +
 rtl/simon_key_step.sv | 32 +++
 rtl/simon_decrypt.sv | 122 ++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// simon_pkg : shared Simon 32/64 constants, state type and rotation helpers
// Revision  : 1.0
// ============================================================================
package simon_pkg;

    localparam int WORD_W       = 16;
    localparam int KEY_WORDS    = 4;
    localparam int ROUNDS       = 32;
    localparam int EXPAND_STEPS = 28;

    localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;
    // Z0[61] holds sequence bit 0 (leftmost character of z0)
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPAND  = 2'd1,
        ST_DECRYPT = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    // Indices past the end of the sequence only occur in don't-care key steps
    function automatic logic z0_bit(input logic [5:0] idx);
        return (idx < 6'd62) ? Z0[6'd61 - idx] : 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_decrypt_if.sv
`default_nettype none
// ============================================================================
// simon_decrypt_if : request/result bundle for the Simon 32/64 decryptor
// Revision         : 1.0
// ============================================================================
interface simon_decrypt_if;
    logic        start;
    logic [63:0] key;
    logic [31:0] cipher_text;
    logic [31:0] plain_text;
    logic        done;
    logic        busy;

    modport master (output start, key, cipher_text, input plain_text, done, busy);
    modport slave  (input start, key, cipher_text, output plain_text, done, busy);
endinterface
`default_nettype wire

// File: rtl/simon_key_step.sv
`default_nettype none
// ============================================================================
// simon_key_step : one forward (dir=0) or backward (dir=1) key-schedule step
// Revision       : 1.0
// ============================================================================
module simon_key_step
    import simon_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_w0,
    input  wire logic [WORD_W-1:0] i_w1,
    input  wire logic [WORD_W-1:0] i_w2,
    input  wire logic [WORD_W-1:0] i_w3,
    input  wire logic              i_z,
    input  wire logic              i_dir,
    output logic      [WORD_W-1:0] o_key
);

    logic [WORD_W-1:0] w_tmp_a;
    logic [WORD_W-1:0] w_tmp;
    logic [WORD_W-1:0] w_base;

    // Backward step solves the forward recurrence for its oldest word:
    // the newest word takes the role of ~W0 and the mix uses the two words below it.
    always_comb begin
        w_tmp_a = i_dir ? (ror(i_w2, 3) ^ i_w0) : (ror(i_w3, 3) ^ i_w1);
        w_tmp   = w_tmp_a ^ ror(w_tmp_a, 1);
        w_base  = i_dir ? i_w3 : i_w0;
        o_key   = w_base ^ C_CONST ^ w_tmp ^ {{(WORD_W-1){1'b0}}, i_z};
    end

endmodule
`default_nettype wire

// File: rtl/simon_decrypt.sv
`default_nettype none
// ============================================================================
// simon_decrypt : iterative Simon 32/64 decryptor, forward key expansion then
//                 32 inverse rounds with on-the-fly backward key regeneration
// Revision      : 1.0
// ============================================================================
module simon_decrypt
    import simon_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    simon_decrypt_if.slave   bus
);

    localparam logic [5:0] c_EXPAND_LAST = 6'(EXPAND_STEPS - 1);
    localparam logic [5:0] c_J_FIRST     = 6'(EXPAND_STEPS);
    // j counts down from 28 through zero and wraps; 61 is j = -3, the 32nd round
    localparam logic [5:0] c_J_LAST      = 6'(EXPAND_STEPS + 64 - ROUNDS + 1);

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic [WORD_W-1:0] r_w0, r_w1, r_w2, r_w3;
    logic [WORD_W-1:0] r_x, r_y;
    logic [31:0]       r_pt;
    logic              r_done;
    logic              r_busy;

    logic              w_dir;
    logic [5:0]        w_z_idx;
    logic              w_z;
    logic [WORD_W-1:0] w_knext;
    logic [WORD_W-1:0] w_f;
    logic [WORD_W-1:0] w_round_y;

    always_comb begin
        w_dir     = (r_state == ST_DECRYPT);
        w_z_idx   = w_dir ? (r_cnt - 6'd1) : r_cnt;
        w_z       = z0_bit(w_z_idx);
        w_f       = (rol(r_y, 1) & rol(r_y, 8)) ^ rol(r_y, 2);
        w_round_y = r_x ^ w_f ^ r_w3;
    end

    simon_key_step u_key_step (
        .i_w0  (r_w0),
        .i_w1  (r_w1),
        .i_w2  (r_w2),
        .i_w3  (r_w3),
        .i_z   (w_z),
        .i_dir (w_dir),
        .o_key (w_knext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_pt    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_w0    <= bus.key[15:0];
                        r_w1    <= bus.key[31:16];
                        r_w2    <= bus.key[47:32];
                        r_w3    <= bus.key[63:48];
                        r_x     <= bus.cipher_text[31:16];
                        r_y     <= bus.cipher_text[15:0];
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    r_w0 <= r_w1;
                    r_w1 <= r_w2;
                    r_w2 <= r_w3;
                    r_w3 <= w_knext;
                    if (r_cnt == c_EXPAND_LAST) begin
                        r_cnt   <= c_J_FIRST;
                        r_state <= ST_DECRYPT;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DECRYPT: begin
                    r_x  <= r_y;
                    r_y  <= w_round_y;
                    r_w3 <= r_w2;
                    r_w2 <= r_w1;
                    r_w1 <= r_w0;
                    r_w0 <= w_knext;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == c_J_LAST) begin
                        r_pt    <= {r_y, w_round_y};
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.plain_text = r_pt;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
